imem_loader: RTL and testbench

- Boot-time program loader that sits directly upstream of cpu_top.
- Accepts a byte stream over a valid/ready handshake and assembles little-endian 32-bit instruction words.
- Writes each word into the instruction memory at byte addresses BASE_ADDR, +4, +8, …, matching the byte-address indexing of instr_mem.
- Holds the core in reset until the full program is written, then releases it. This replaces testbench backdoor preloading of instr_mem.

---
 rtl/imem_loader.sv | 158 +++++++++++++++
 tb/tb_imem_loader.sv | 401 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_loader.sv
// Boot-time loader: assembles little-endian words from a byte stream, writes them to
// instruction memory and holds the core in reset until done. Optional IMEM_LOADER_CHECKSUM_EN.
module imem_loader #(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDR_WIDTH    = 10,
  parameter int BASE_ADDR     = 0,
  parameter int RELEASE_DELAY = 4
) (
  input  logic                  i_clk,
  input  logic                  i_reset_n,
  input  logic                  i_start,
  input  logic [ADDR_WIDTH-2:0] i_len_words,
  input  logic                  i_byte_valid,
  input  logic [7:0]            i_byte_data,
  output logic                  o_byte_ready,
  output logic                  o_imem_we,
  output logic [ADDR_WIDTH-1:0] o_imem_addr,
  output logic [DATA_WIDTH-1:0] o_imem_wdata,
  output logic                  o_core_reset_n,
  output logic                  o_busy,
  output logic                  o_done,
  output logic                  o_error
);
  localparam int LW = ADDR_WIDTH - 1;
  localparam int CW = ADDR_WIDTH + 2;
  localparam int HW = $clog2(RELEASE_DELAY + 1) + 1;
  localparam logic [CW-1:0]         LIMIT     = CW'(2 ** ADDR_WIDTH);
  localparam logic [CW-1:0]         BASE_C    = CW'(BASE_ADDR);
  localparam logic [ADDR_WIDTH-1:0] BASE_A    = ADDR_WIDTH'(BASE_ADDR);
  localparam logic [HW-1:0]         HOLD_LAST = HW'(RELEASE_DELAY);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
`ifdef IMEM_LOADER_CHECKSUM_EN
    S_CHECK,
`endif
    S_HOLD,
    S_RUN,
    S_ERROR
  } state_t;

  state_t                  state_q;
  logic [1:0]              byte_cnt_q;
  logic [LW-1:0]           word_cnt_q;
  logic [LW-1:0]           len_q;
  logic [23:0]             shift_q;
  logic [HW-1:0]           hold_q;
  logic                    we_q;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [DATA_WIDTH-1:0]   wdata_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0]              csum_q;
`endif

  logic [CW-1:0] end_addr;
  logic          start_ok;
  logic          accept;

  // Widened end address so an oversize length cannot wrap past the limit check.
  always_comb begin
    end_addr = BASE_C + {1'b0, i_len_words, 2'b00};
    start_ok = (i_len_words != '0) && (end_addr <= LIMIT);
  end

  always_comb begin
`ifdef IMEM_LOADER_CHECKSUM_EN
    o_byte_ready = (state_q == S_LOAD) || (state_q == S_CHECK);
    o_busy       = (state_q == S_LOAD) || (state_q == S_CHECK) || (state_q == S_HOLD);
`else
    o_byte_ready = (state_q == S_LOAD);
    o_busy       = (state_q == S_LOAD) || (state_q == S_HOLD);
`endif
    o_done         = (state_q == S_RUN);
    o_core_reset_n = (state_q == S_RUN);
    o_error        = (state_q == S_ERROR);
    o_imem_we      = we_q;
    o_imem_addr    = addr_q;
    o_imem_wdata   = wdata_q;
    accept         = i_byte_valid & o_byte_ready;
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      state_q    <= S_IDLE;
      byte_cnt_q <= '0;
      word_cnt_q <= '0;
      len_q      <= '0;
      shift_q    <= '0;
      hold_q     <= '0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      csum_q     <= '0;
`endif
    end else begin
      we_q <= 1'b0;
      case (state_q)
        S_IDLE, S_RUN, S_ERROR: begin
          if (i_start) begin
            if (start_ok) begin
              len_q      <= i_len_words;
              byte_cnt_q <= '0;
              word_cnt_q <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
              csum_q     <= '0;
`endif
              state_q    <= S_LOAD;
            end else begin
              state_q <= S_ERROR;
            end
          end
        end
        S_LOAD: begin
          if (accept) begin
            shift_q    <= {i_byte_data, shift_q[23:8]};
            byte_cnt_q <= byte_cnt_q + 2'd1;
`ifdef IMEM_LOADER_CHECKSUM_EN
            csum_q     <= csum_q ^ i_byte_data;
`endif
            // Byte 3 completes the word; the write strobe fires on the following cycle.
            if (byte_cnt_q == 2'd3) begin
              we_q       <= 1'b1;
              addr_q     <= BASE_A + ADDR_WIDTH'({word_cnt_q, 2'b00});
              wdata_q    <= {i_byte_data, shift_q};
              word_cnt_q <= word_cnt_q + LW'(1);
              if (word_cnt_q == len_q - LW'(1)) begin
                hold_q  <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
                state_q <= S_CHECK;
`else
                state_q <= S_HOLD;
`endif
              end
            end
          end
        end
`ifdef IMEM_LOADER_CHECKSUM_EN
        S_CHECK: begin
          if (accept) begin
            hold_q  <= '0;
            state_q <= (i_byte_data == csum_q) ? S_HOLD : S_ERROR;
          end
        end
`endif
        S_HOLD: begin
          if (hold_q == HOLD_LAST) begin
            state_q <= S_RUN;
          end else begin
            hold_q <= hold_q + HW'(1);
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_imem_loader.sv
// Directed self-checking bench for imem_loader; checksum scenarios build only with
// IMEM_LOADER_CHECKSUM_EN defined.
module tb_imem_loader;
  localparam int AW = 10;
  localparam int RD = 4;

  logic          i_clk = 1'b0;
  logic          i_reset_n;
  logic          i_start;
  logic [AW-2:0] i_len_words;
  logic          i_byte_valid;
  logic [7:0]    i_byte_data;
  logic          o_byte_ready;
  logic          o_imem_we;
  logic [AW-1:0] o_imem_addr;
  logic [31:0]   o_imem_wdata;
  logic          o_core_reset_n;
  logic          o_busy;
  logic          o_done;
  logic          o_error;

  imem_loader #(
    .DATA_WIDTH(32),
    .ADDR_WIDTH(AW),
    .BASE_ADDR(0),
    .RELEASE_DELAY(RD)
  ) dut (
    .i_clk(i_clk),
    .i_reset_n(i_reset_n),
    .i_start(i_start),
    .i_len_words(i_len_words),
    .i_byte_valid(i_byte_valid),
    .i_byte_data(i_byte_data),
    .o_byte_ready(o_byte_ready),
    .o_imem_we(o_imem_we),
    .o_imem_addr(o_imem_addr),
    .o_imem_wdata(o_imem_wdata),
    .o_core_reset_n(o_core_reset_n),
    .o_busy(o_busy),
    .o_done(o_done),
    .o_error(o_error)
  );

  always #5 i_clk = ~i_clk;

  localparam logic [31:0] W0 = 32'hFF4F2B23;
  localparam logic [31:0] W1 = 32'h00112023;
  localparam logic [31:0] W2 = 32'h00552423;

  int unsigned   cyc = 0;
  logic [AW-1:0] wr_addr[$];
  logic [31:0]   wr_data[$];
  int unsigned   wr_cyc[$];
  int            n_chk = 0;
  int            n_fail = 0;
  logic [7:0]    run_xor;

  always @(posedge i_clk) cyc <= cyc + 1;

  always @(negedge i_clk) begin
    if (o_imem_we === 1'b1) begin
      wr_addr.push_back(o_imem_addr);
      wr_data.push_back(o_imem_wdata);
      wr_cyc.push_back(cyc);
    end
  end

  task automatic clear_log();
    wr_addr.delete();
    wr_data.delete();
    wr_cyc.delete();
  endtask

  task automatic do_reset();
    i_reset_n = 1'b0; i_start = 1'b0; i_len_words = '0;
    i_byte_valid = 1'b0; i_byte_data = '0;
    repeat (2) @(negedge i_clk);
    i_reset_n = 1'b1;
    clear_log();
  endtask

  task automatic start_load(input logic [AW-2:0] len);
    i_start = 1'b1; i_len_words = len; run_xor = '0;
    @(negedge i_clk);
    i_start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    bit ok;
    ok = 1'b0;
    i_byte_valid = 1'b1; i_byte_data = b;
    for (int t = 0; t < 64; t++) begin
      if (o_byte_ready === 1'b1) begin
        ok = 1'b1;
        @(negedge i_clk);
        break;
      end
      @(negedge i_clk);
    end
    i_byte_valid = 1'b0;
    if (ok) run_xor = run_xor ^ b;
    else begin
      n_chk++; n_fail++;
      $display("FAIL send_byte_timeout: ready=%b, required 1 within 64 cycles", o_byte_ready);
    end
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int k = 0; k < 4; k++) send_byte(w[8*k +: 8]);
  endtask

  task automatic finish_load();
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0] c;
    c = run_xor;
    send_byte(c);
`endif
  endtask

  task automatic wait_release(output int n);
    n = 0;
    while (o_core_reset_n !== 1'b1 && n < 40) begin
      @(negedge i_clk);
      n++;
    end
  endtask

  task automatic test_reset();
    i_reset_n = 1'b0; i_start = 1'b1; i_len_words = 9'd1;
    i_byte_valid = 1'b1; i_byte_data = 8'h5A;
    repeat (2) @(negedge i_clk);
    n_chk++; if ({o_busy, o_done, o_error, o_byte_ready, o_imem_we, o_core_reset_n} !== 6'b0) begin
      n_fail++; $display("FAIL reset_flags: got %b, required 000000",
        {o_busy, o_done, o_error, o_byte_ready, o_imem_we, o_core_reset_n});
    end
    n_chk++; if (o_imem_addr !== '0 || o_imem_wdata !== '0) begin
      n_fail++; $display("FAIL reset_bus: addr=%h wdata=%h, required 0/0", o_imem_addr, o_imem_wdata);
    end
    do_reset();
  endtask

  task automatic test_single_word();
    int n;
    do_reset();
    start_load(9'd1);
    n_chk++; if (o_busy !== 1'b1 || o_byte_ready !== 1'b1 || o_core_reset_n !== 1'b0) begin
      n_fail++; $display("FAIL single_load_entry: busy=%b ready=%b core=%b, required 1 1 0",
        o_busy, o_byte_ready, o_core_reset_n);
    end
    send_word(W0);
    n_chk++; if (o_imem_we !== 1'b1 || o_imem_addr !== 10'h000 || o_imem_wdata !== W0) begin
      n_fail++; $display("FAIL single_write: we=%b addr=%h data=%h, required 1 000 %h",
        o_imem_we, o_imem_addr, o_imem_wdata, W0);
    end
`ifndef IMEM_LOADER_CHECKSUM_EN
    n_chk++; if (o_byte_ready !== 1'b0) begin
      n_fail++; $display("FAIL single_ready_drop: ready=%b, required 0", o_byte_ready);
    end
`endif
    finish_load();
    wait_release(n);
    n_chk++; if (n != RD + 1) begin
      n_fail++; $display("FAIL single_release_delay: %0d cycles, required %0d", n, RD + 1);
    end
    n_chk++; if (o_done !== 1'b1 || o_busy !== 1'b0 || o_error !== 1'b0) begin
      n_fail++; $display("FAIL single_run_flags: done=%b busy=%b err=%b, required 1 0 0",
        o_done, o_busy, o_error);
    end
    #1;
    n_chk++; if (wr_addr.size() != 1) begin
      n_fail++; $display("FAIL single_write_count: %0d writes, required 1", wr_addr.size());
    end
  endtask

  task automatic test_back_to_back();
    int n;
    bit seen_ready;
    do_reset();
    start_load(9'd3);
    send_word(W0); send_word(W1); send_word(W2);
`ifndef IMEM_LOADER_CHECKSUM_EN
    n_chk++; if (o_byte_ready !== 1'b0) begin
      n_fail++; $display("FAIL b2b_ready_after_12: ready=%b, required 0", o_byte_ready);
    end
    seen_ready = 1'b0;
    i_byte_valid = 1'b1; i_byte_data = 8'h77;
    repeat (4) begin
      @(negedge i_clk);
      if (o_byte_ready !== 1'b0) seen_ready = 1'b1;
    end
    i_byte_valid = 1'b0;
    n_chk++; if (seen_ready !== 1'b0) begin
      n_fail++; $display("FAIL b2b_excess_byte: ready seen=%b, required 0", seen_ready);
    end
`endif
    finish_load();
    wait_release(n);
    #1;
    n_chk++; if (wr_addr.size() != 3) begin
      n_fail++; $display("FAIL b2b_write_count: %0d, required 3", wr_addr.size());
    end else begin
      n_chk++; if (wr_addr[0] !== 10'h000 || wr_addr[1] !== 10'h004 || wr_addr[2] !== 10'h008) begin
        n_fail++; $display("FAIL b2b_addrs: %h %h %h, required 000 004 008", wr_addr[0], wr_addr[1], wr_addr[2]);
      end
      n_chk++; if (wr_data[0] !== W0 || wr_data[1] !== W1 || wr_data[2] !== W2) begin
        n_fail++; $display("FAIL b2b_data: %h %h %h, required %h %h %h",
          wr_data[0], wr_data[1], wr_data[2], W0, W1, W2);
      end
      n_chk++; if (wr_cyc[1] - wr_cyc[0] != 4 || wr_cyc[2] - wr_cyc[1] != 4) begin
        n_fail++; $display("FAIL b2b_spacing: %0d %0d cycles, required 4 4",
          wr_cyc[1] - wr_cyc[0], wr_cyc[2] - wr_cyc[1]);
      end
    end
  endtask

  task automatic test_stalled();
    int n;
    int gaps[8] = '{1, 0, 3, 2, 0, 1, 0, 2};
    logic [63:0] stream;
    stream = {W2, W1};
    do_reset();
    start_load(9'd2);
    for (int i = 0; i < 8; i++) begin
      repeat (gaps[i]) begin
        i_byte_data = 8'hC3;
        @(negedge i_clk);
      end
      send_byte(stream[8*i +: 8]);
      if (i == 1) begin
        i_start = 1'b1; i_len_words = '0;
        @(negedge i_clk);
        i_start = 1'b0;
        n_chk++; if (o_error !== 1'b0 || o_busy !== 1'b1) begin
          n_fail++; $display("FAIL stall_start_ignored: err=%b busy=%b, required 0 1", o_error, o_busy);
        end
      end
      if (i == 2) begin
        #1;
        n_chk++; if (wr_addr.size() != 0 || o_imem_we !== 1'b0) begin
          n_fail++; $display("FAIL stall_early_write: writes=%0d we=%b, required 0 0", wr_addr.size(), o_imem_we);
        end
      end
      if (i == 3) begin
        n_chk++; if (o_imem_we !== 1'b1 || o_imem_wdata !== W1) begin
          n_fail++; $display("FAIL stall_first_write: we=%b data=%h, required 1 %h", o_imem_we, o_imem_wdata, W1);
        end
      end
    end
    finish_load();
    wait_release(n);
    #1;
    n_chk++; if (wr_addr.size() != 2) begin
      n_fail++; $display("FAIL stall_write_count: %0d, required 2", wr_addr.size());
    end else begin
      n_chk++; if (wr_addr[0] !== 10'h000 || wr_addr[1] !== 10'h004 || wr_data[0] !== W1 || wr_data[1] !== W2) begin
        n_fail++; $display("FAIL stall_writes: %h=%h %h=%h, required 000=%h 004=%h",
          wr_addr[0], wr_data[0], wr_addr[1], wr_data[1], W1, W2);
      end
    end
  endtask

  task automatic test_bounds();
    int n;
    int bad;
    logic [31:0] w;
    do_reset();
    start_load(9'd0);
    n_chk++; if (o_error !== 1'b1 || o_core_reset_n !== 1'b0 || o_byte_ready !== 1'b0 || o_busy !== 1'b0) begin
      n_fail++; $display("FAIL bounds_len0: err=%b core=%b ready=%b busy=%b, required 1 0 0 0",
        o_error, o_core_reset_n, o_byte_ready, o_busy);
    end
    do_reset();
    start_load(9'd257);
    n_chk++; if (o_error !== 1'b1) begin
      n_fail++; $display("FAIL bounds_len257: err=%b, required 1", o_error);
    end
    start_load(9'd256);
    n_chk++; if (o_error !== 1'b0 || o_busy !== 1'b1) begin
      n_fail++; $display("FAIL bounds_len256_accept: err=%b busy=%b, required 0 1", o_error, o_busy);
    end
    for (int i = 0; i < 256; i++) begin
      for (int k = 0; k < 4; k++) w[8*k +: 8] = 8'((4*i + k) % 256);
      send_word(w);
    end
    finish_load();
    wait_release(n);
    n_chk++; if (o_done !== 1'b1) begin
      n_fail++; $display("FAIL bounds_len256_done: done=%b, required 1", o_done);
    end
    #1;
    n_chk++; if (wr_addr.size() != 256) begin
      n_fail++; $display("FAIL bounds_len256_count: %0d, required 256", wr_addr.size());
    end else begin
      n_chk++; if (wr_addr[255] !== 10'h3FC) begin
        n_fail++; $display("FAIL bounds_last_addr: %h, required 3fc", wr_addr[255]);
      end
      bad = 0;
      for (int i = 0; i < 256; i++) begin
        for (int k = 0; k < 4; k++) w[8*k +: 8] = 8'((4*i + k) % 256);
        if (wr_addr[i] !== 10'(4*i) || wr_data[i] !== w) bad++;
      end
      n_chk++; if (bad != 0) begin
        n_fail++; $display("FAIL bounds_full_sequence: %0d bad writes, required 0", bad);
      end
    end
  endtask

  task automatic test_restart_from_run();
    int n;
    clear_log();
    start_load(9'd1);
    n_chk++; if (o_core_reset_n !== 1'b0 || o_busy !== 1'b1 || o_done !== 1'b0) begin
      n_fail++; $display("FAIL restart_entry: core=%b busy=%b done=%b, required 0 1 0",
        o_core_reset_n, o_busy, o_done);
    end
    send_word(32'hDEADBEEF);
    finish_load();
    wait_release(n);
    #1;
    n_chk++; if (wr_addr.size() != 1 || wr_addr[0] !== 10'h000 || wr_data[0] !== 32'hDEADBEEF) begin
      n_fail++; $display("FAIL restart_write: count=%0d, required one write of deadbeef at 000", wr_addr.size());
    end
    start_load(9'd0);
    n_chk++; if (o_error !== 1'b1 || o_core_reset_n !== 1'b0) begin
      n_fail++; $display("FAIL restart_bad_len: err=%b core=%b, required 1 0", o_error, o_core_reset_n);
    end
  endtask

  task automatic test_reset_mid_load();
    int n;
    do_reset();
    start_load(9'd3);
    send_word(W0);
    send_byte(W1[7:0]);
    send_byte(W1[15:8]);
    i_reset_n = 1'b0;
    @(negedge i_clk);
    n_chk++; if ({o_busy, o_done, o_error, o_byte_ready, o_imem_we, o_core_reset_n} !== 6'b0
                 || o_imem_addr !== '0 || o_imem_wdata !== '0) begin
      n_fail++; $display("FAIL midreset_outputs: flags=%b addr=%h data=%h, required 0",
        {o_busy, o_done, o_error, o_byte_ready, o_imem_we, o_core_reset_n}, o_imem_addr, o_imem_wdata);
    end
    i_reset_n = 1'b1;
    clear_log();
    start_load(9'd1);
    send_word(W2);
    finish_load();
    wait_release(n);
    #1;
    n_chk++; if (wr_addr.size() != 1 || wr_addr[0] !== 10'h000 || wr_data[0] !== W2) begin
      n_fail++; $display("FAIL midreset_fresh_load: count=%0d, required one write of %h at 000", wr_addr.size(), W2);
    end
  endtask

`ifdef IMEM_LOADER_CHECKSUM_EN
  task automatic test_checksum();
    int n;
    do_reset();
    start_load(9'd1);
    send_word(32'h08040201);
    send_byte(8'h0F);
    wait_release(n);
    n_chk++; if (o_done !== 1'b1 || o_error !== 1'b0) begin
      n_fail++; $display("FAIL csum_match: done=%b err=%b, required 1 0", o_done, o_error);
    end
    do_reset();
    start_load(9'd1);
    send_word(32'h08040201);
    send_byte(8'h0E);
    repeat (RD + 2) @(negedge i_clk);
    n_chk++; if (o_error !== 1'b1 || o_core_reset_n !== 1'b0) begin
      n_fail++; $display("FAIL csum_mismatch: err=%b core=%b, required 1 0", o_error, o_core_reset_n);
    end
    #1;
    n_chk++; if (wr_addr.size() != 1 || wr_data[0] !== 32'h08040201) begin
      n_fail++; $display("FAIL csum_word_written: count=%0d, required one write of 08040201", wr_addr.size());
    end
  endtask
`endif

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single_word();
    test_back_to_back();
    test_stalled();
    test_bounds();
    test_restart_from_run();
    test_reset_mid_load();
`ifdef IMEM_LOADER_CHECKSUM_EN
    test_checksum();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
